// File: rtl/multi_phase_light_controller_if.sv
// Sensor, pedestrian, reprogramming and lamp signals of the multi-phase light controller.
// The master side drives requests and configuration; the slave side drives the lamps.
interface multi_phase_light_controller_if #(
    parameter int NUM_PHASES = 4,
    parameter int TIME_W     = 4
);
    localparam int PH_W = $clog2(NUM_PHASES);

    logic [NUM_PHASES-1:0] sensor;
    logic                  walk_request;
    logic                  reprogram;
    logic [1:0]            time_param_selector;
    logic [TIME_W-1:0]     time_value;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] green;
    logic                  walk;
    logic [PH_W-1:0]       active_phase;
    logic [1:0]            state;
    logic                  expired;

    modport master (
        output sensor, walk_request, reprogram, time_param_selector, time_value,
        input  red, yellow, green, walk, active_phase, state, expired
    );

    modport slave (
        input  sensor, walk_request, reprogram, time_param_selector, time_value,
        output red, yellow, green, walk, active_phase, state, expired
    );
endinterface

// File: rtl/multi_phase_light_controller.sv
// Round-robin traffic-light sequencer: green then yellow per phase, one sensor-driven
// green extension, a latched pedestrian walk interval, and run-time interval registers.
module multi_phase_light_controller #(
    parameter int NUM_PHASES = 4,
    parameter int TIME_W     = 4,
    parameter int TICK_DIV   = 50000000,
    parameter int DEF_GREEN  = 6,
    parameter int DEF_YELLOW = 2,
    parameter int DEF_WALK   = 3,
    parameter int DEF_EXT    = 3
) (
    input logic                           clock,
    input logic                           reset,
    multi_phase_light_controller_if.slave bus
);
    // state    | meaning
    // S_GREEN  | active_phase green, all other phases red
    // S_YELLOW | active_phase yellow, all other phases red
    // S_WALK   | all phases red, walk lamp lit
    localparam int PH_W  = $clog2(NUM_PHASES);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] ONE       = TIME_W'(1);
    localparam logic [TIME_W-1:0] TIMER_RST = (DEF_GREEN == 0) ? ONE : TIME_W'(DEF_GREEN);

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_WALK   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d, phase_nxt;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [TIME_W-1:0]     timer_q, timer_d;
    logic                  ext_q, ext_d;
    logic                  pend_q, pend_d;
    logic                  expired_q, expired_d;
    logic [TIME_W-1:0]     t_green_q, t_green_d, t_yellow_q, t_yellow_d;
    logic [TIME_W-1:0]     t_walk_q, t_walk_d, t_ext_q, t_ext_d;
    logic [NUM_PHASES-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
    logic                  walk_q, walk_d;
    logic                  tick, expire;

    // A programmed interval of zero still lasts one second.
    function automatic logic [TIME_W-1:0] load_val(input logic [TIME_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    assign phase_nxt = (phase_q == PH_W'(NUM_PHASES - 1)) ? '0 : phase_q + PH_W'(1);

    always_comb begin
        t_green_d  = t_green_q;
        t_yellow_d = t_yellow_q;
        t_walk_d   = t_walk_q;
        t_ext_d    = t_ext_q;
        if (bus.reprogram) begin
            case (bus.time_param_selector)
                2'd0:    t_green_d  = bus.time_value;
                2'd1:    t_yellow_d = bus.time_value;
                2'd2:    t_walk_d   = bus.time_value;
                default: t_ext_d    = bus.time_value;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ext_d   = ext_q;
        pend_d  = pend_q;
        tick    = (presc_q == PRE_LAST);
        expire  = tick && (timer_q == ONE);
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
        timer_d = tick ? timer_q - ONE : timer_q;

        // Every reload below uses the interval registers as they stood before this edge.
        if (expire) begin
            presc_d = '0;
            case (state_q)
                S_GREEN: begin
                    if (bus.sensor[phase_q] && !ext_q) begin
                        ext_d   = 1'b1;
                        timer_d = load_val(t_ext_q);
                    end else begin
                        state_d = S_YELLOW;
                        timer_d = load_val(t_yellow_q);
                    end
                end
                S_YELLOW: begin
                    if (pend_q) begin
                        state_d = S_WALK;
                        pend_d  = 1'b0;
                        timer_d = load_val(t_walk_q);
                    end else begin
                        state_d = S_GREEN;
                        phase_d = phase_nxt;
                        ext_d   = 1'b0;
                        timer_d = load_val(t_green_q);
                    end
                end
                default: begin
                    state_d = S_GREEN;
                    phase_d = phase_nxt;
                    ext_d   = 1'b0;
                    timer_d = load_val(t_green_q);
                end
            endcase
        end

        if (bus.walk_request) pend_d = 1'b1;

        green_d  = '0;
        yellow_d = '0;
        if (state_d == S_GREEN)  green_d[phase_d]  = 1'b1;
        if (state_d == S_YELLOW) yellow_d[phase_d] = 1'b1;
        red_d     = ~(green_d | yellow_d);
        walk_d    = (state_d == S_WALK);
        // Registered look-ahead so expired is high during the final cycle of an interval.
        expired_d = (presc_d == PRE_LAST) && (timer_d == ONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_GREEN;
            phase_q    <= '0;
            presc_q    <= '0;
            timer_q    <= TIMER_RST;
            ext_q      <= 1'b0;
            pend_q     <= 1'b0;
            expired_q  <= 1'b0;
            t_green_q  <= TIME_W'(DEF_GREEN);
            t_yellow_q <= TIME_W'(DEF_YELLOW);
            t_walk_q   <= TIME_W'(DEF_WALK);
            t_ext_q    <= TIME_W'(DEF_EXT);
            green_q    <= NUM_PHASES'(1);
            yellow_q   <= '0;
            red_q      <= ~NUM_PHASES'(1);
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            presc_q    <= presc_d;
            timer_q    <= timer_d;
            ext_q      <= ext_d;
            pend_q     <= pend_d;
            expired_q  <= expired_d;
            t_green_q  <= t_green_d;
            t_yellow_q <= t_yellow_d;
            t_walk_q   <= t_walk_d;
            t_ext_q    <= t_ext_d;
            green_q    <= green_d;
            yellow_q   <= yellow_d;
            red_q      <= red_d;
            walk_q     <= walk_d;
        end
    end

    assign bus.red          = red_q;
    assign bus.yellow       = yellow_q;
    assign bus.green        = green_q;
    assign bus.walk         = walk_q;
    assign bus.active_phase = phase_q;
    assign bus.state        = state_q;
    assign bus.expired      = expired_q;
endmodule
